framed_shiftregister: RTL and testbench
=======================================

# framed_shiftregister

Parametrised full-duplex shift engine and successor to the plain serial/parallel shift register. A word loaded through a valid/ready handshake is shifted out MSB-first or LSB-first, one bit per peripheral clock edge, while serial input is captured. After exactly `width` edges the block reports frame completion with a single-cycle pulse and presents the received word. It sits between the SPI-style peripheral edge detector and the word-level controller.

## Interface
- `width`, 8, word length in bits; legal range 2..32.
- `countWidth`, `$clog2(width)`, bit-counter width; derived, never overridden.

- `clk`  in  1  FPGA clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `peripheralClkEdge`  in  1  single-cycle shift strobe.
- `loadValid`  in  1  `parallelDataIn` and `lsbFirst` are offered.
- `loadReady`  out  1  high only in IDLE.
- `parallelDataIn`  in  width  word to transmit.
- `lsbFirst`  in  1  bit order; sampled only at load (1 = LSB first).
- `serialDataIn`  in  1  received bit; sampled on each accepted edge.
- `serialDataOut`  out  1  current transmit bit.
- `parallelDataOut`  out  width  shift register contents.
- `busy`  out  1  high in SHIFTING.
- `frameDone`  out  1  one-cycle pulse in DONE.

## Operation
- The FSM has three states:
  - IDLE → SHIFTING when `loadValid && loadReady`. The register loads `parallelDataIn`, the order flag latches `lsbFirst`, and `bitCount` is set to 0.
  - SHIFTING → DONE on the edge where `bitCount == width-1`.
  - DONE → IDLE unconditionally after 1 cycle.
- The shift happens only in SHIFTING with `peripheralClkEdge` = 1:
  - MSB-first: `mem <= {mem[width-2:0], serialDataIn}`; `serialDataOut = mem[width-1]`.
  - LSB-first: `mem <= {serialDataIn, mem[width-1:1]}`; `serialDataOut = mem[0]`.
  - `bitCount` increments by 1 per edge and never wraps within a frame.
- After `width` edges, `parallelDataOut` holds the received word in natural bit order for both modes. It holds that value until the next load.
- `peripheralClkEdge` is ignored in IDLE and DONE, so edges do not disturb the register.
- `loadValid` is ignored outside IDLE, because `loadReady` = 0 there.
- A load and an edge in the same IDLE cycle: the load is taken and the edge is dropped. The first shift uses the next edge.
- `lsbFirst` changes during a frame have no effect.
- `reset` has priority over everything, including mid-frame. The frame is abandoned, with no `frameDone` pulse.

## Timing
- Reset values:
  - state IDLE; `mem` = 0; `bitCount` = 0; order flag = 0 (MSB-first).
  - `serialDataOut` = 0, `parallelDataOut` = 0, `busy` = 0, `frameDone` = 0, `loadReady` = 1.
- Load latency: the first transmit bit is valid on `serialDataOut` in the cycle after acceptance.
- `serialDataOut` changes only on the clock after an accepted edge.
- `frameDone` asserts in the cycle after the `width`-th edge, for exactly 1 cycle.
- `loadReady` rises 1 cycle after `frameDone`.
- Minimum frame period is `width` edges + 2 cycles; the fastest case is an edge every cycle.
- All outputs are registered or decoded directly from the state register. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `shiftregister_pkg`:
  - state encoding localparams `ST_IDLE` = 2'd0, `ST_SHIFTING` = 2'd1, `ST_DONE` = 2'd2;
  - order constants `ORDER_MSB` = 0, `ORDER_LSB` = 1.
- One sub-module, `shiftregister_core`:
  - the width-parametrised data register with load, direction-selected shift and serial tap;
  - controlled by the FSM through `load`, `shift` and `dir` strobes.
- The top level holds the FSM, `bitCount` and the handshake.

## Test plan
- **Reset:** assert `reset` 2 cycles with random inputs → all outputs at reset values; `loadReady` = 1.
- **MSB-first full duplex:** `width` = 8; load 0xA5 with `lsbFirst` = 0; 8 edges with `serialDataIn` bits of 0x3C MSB-first → `serialDataOut` = 1,0,1,0,0,1,0,1. `frameDone` is a single pulse 1 cycle after the 8th edge; `parallelDataOut` = 0x3C.
- **LSB-first:** load 0x01 with `lsbFirst` = 1; feed 0x80 LSB-first → `serialDataOut` = 1,0,0,0,0,0,0,0; final `parallelDataOut` = 0x80.
- **Ignored inputs:** edges in IDLE leave `mem` unchanged. `loadValid` while `busy` is ignored and the frame contents are unaffected. A load and an edge in the same cycle → exactly 8 further edges are needed for `frameDone`.
- **Irregular edges:** edges spaced 1–5 cycles at random → `bitCount` and `frameDone` timing correct. Back-to-back loads give a frame period of 8 edges + 2 cycles.
- **Mid-frame reset:** `reset` after 3 edges → reset values next cycle, no `frameDone`. A new load of 0xFF then completes normally.

Source files
------------

// File: rtl/shiftregister_pkg.sv
// Shared state encoding and bit-order constants for the framed shift engine.
package shiftregister_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SHIFTING = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;

    localparam logic ORDER_MSB = 1'b0;
    localparam logic ORDER_LSB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE     = ST_IDLE,
        S_SHIFTING = ST_SHIFTING,
        S_DONE     = ST_DONE
    } state_e;

endpackage

// File: rtl/shiftregister_core.sv
// Width-parametrised data register: parallel load, direction-selected shift, serial tap.
module shiftregister_core
    import shiftregister_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             dir,
    input  logic [width-1:0] load_data,
    input  logic             serial_in,
    output logic [width-1:0] mem,
    output logic             serial_out
);

    logic [width-1:0] mem_q;
    logic [width-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (load) begin
            mem_d = load_data;
        end else if (shift) begin
            if (dir == ORDER_LSB) begin
                mem_d = {serial_in, mem_q[width-1:1]};
            end else begin
                mem_d = {mem_q[width-2:0], serial_in};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // dir comes from a register in the controller, so the tap stays a registered path
    assign serial_out = (dir == ORDER_LSB) ? mem_q[0] : mem_q[width-1];
    assign mem        = mem_q;

endmodule

// File: rtl/framed_shiftregister.sv
// Framed full-duplex shift engine: handshake load, width edges of shifting, one-cycle done pulse.
module framed_shiftregister
    import shiftregister_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             peripheralClkEdge,
    input  logic             loadValid,
    output logic             loadReady,
    input  logic [width-1:0] parallelDataIn,
    input  logic             lsbFirst,
    input  logic             serialDataIn,
    output logic             serialDataOut,
    output logic [width-1:0] parallelDataOut,
    output logic             busy,
    output logic             frameDone
);

    localparam int countWidth = $clog2(width);
    localparam logic [countWidth-1:0] LAST_BIT = countWidth'(width - 1);

    state_e                state_q, state_d;
    logic [countWidth-1:0] bit_count_q, bit_count_d;
    logic                  order_q, order_d;
    logic                  load_strobe;
    logic                  shift_strobe;

    always_comb begin
        state_d      = state_q;
        bit_count_d  = bit_count_q;
        order_d      = order_q;
        load_strobe  = 1'b0;
        shift_strobe = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A simultaneous edge is deliberately dropped: the load wins.
                if (loadValid) begin
                    state_d     = S_SHIFTING;
                    bit_count_d = '0;
                    order_d     = lsbFirst;
                    load_strobe = 1'b1;
                end
            end
            S_SHIFTING: begin
                if (peripheralClkEdge) begin
                    shift_strobe = 1'b1;
                    if (bit_count_q == LAST_BIT) begin
                        state_d = S_DONE;
                    end else begin
                        bit_count_d = bit_count_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_count_q <= '0;
            order_q     <= ORDER_MSB;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            order_q     <= order_d;
        end
    end

    shiftregister_core #(
        .width(width)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (load_strobe),
        .shift     (shift_strobe),
        .dir       (order_q),
        .load_data (parallelDataIn),
        .serial_in (serialDataIn),
        .mem       (parallelDataOut),
        .serial_out(serialDataOut)
    );

    assign loadReady = (state_q == S_IDLE);
    assign busy      = (state_q == S_SHIFTING);
    assign frameDone = (state_q == S_DONE);

endmodule

// File: tb/tb_framed_shiftregister.sv
// Self-checking bench for framed_shiftregister: vector table, corner sequences, random frames.
module tb_framed_shiftregister;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         peripheralClkEdge;
    logic         loadValid;
    logic         loadReady;
    logic [W-1:0] parallelDataIn;
    logic         lsbFirst;
    logic         serialDataIn;
    logic         serialDataOut;
    logic [W-1:0] parallelDataOut;
    logic         busy;
    logic         frameDone;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int accept_cyc = 0;

    framed_shiftregister #(.width(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .peripheralClkEdge(peripheralClkEdge),
        .loadValid        (loadValid),
        .loadReady        (loadReady),
        .parallelDataIn   (parallelDataIn),
        .lsbFirst         (lsbFirst),
        .serialDataIn     (serialDataIn),
        .serialDataOut    (serialDataOut),
        .parallelDataOut  (parallelDataOut),
        .busy             (busy),
        .frameDone        (frameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] rx;
        logic         lsb;
        logic [W-1:0] exp_seq;   // transmit bits in time order, first bit at [W-1]
        logic [W-1:0] exp_par;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transmit order is the word itself (MSB first) or its bit reversal (LSB first).
    function automatic logic [W-1:0] model_seq(input logic [W-1:0] tx, input logic lsb);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = tx[W-1-i];
        return lsb ? r : tx;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_loadReady"}, loadReady, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frameDone"}, frameDone, 0);
        check({tag, "_sdo"}, serialDataOut, 0);
        check({tag, "_pdo"}, parallelDataOut, 0);
    endtask

    task automatic run_frame(input logic [W-1:0] tx, input logic [W-1:0] rx, input logic lsb,
                             input logic [W-1:0] exp_seq, input logic [W-1:0] exp_par,
                             input int max_gap, input logic edge_at_load, input logic noise);
        int waited;
        int gap;
        waited = 0;
        while (!loadReady && waited < 20) begin
            tick();
            waited++;
        end
        check("ready_before_load", loadReady, 1);
        loadValid         = 1'b1;
        parallelDataIn    = tx;
        lsbFirst          = lsb;
        peripheralClkEdge = edge_at_load;
        serialDataIn      = 1'($urandom);
        tick();
        accept_cyc        = cyc;
        loadValid         = 1'b0;
        peripheralClkEdge = 1'b0;
        check("busy_after_load", busy, 1);
        check("ready_after_load", loadReady, 0);
        for (int k = 0; k < W; k++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap - 1)) : 0;
            for (int g = 0; g < gap; g++) begin
                if (noise) begin
                    loadValid      = 1'($urandom);
                    parallelDataIn = W'($urandom);
                    lsbFirst       = 1'($urandom);
                    serialDataIn   = 1'($urandom);
                end
                tick();
                loadValid = 1'b0;
                check("tx_hold", serialDataOut, exp_seq[W-1-k]);
                check("no_early_done", frameDone, 0);
            end
            check("tx_bit", serialDataOut, exp_seq[W-1-k]);
            check("busy_mid", busy, 1);
            peripheralClkEdge = 1'b1;
            serialDataIn      = lsb ? rx[k] : rx[W-1-k];
            if (noise) begin
                lsbFirst  = 1'($urandom);
                loadValid = 1'($urandom);
            end
            tick();
            peripheralClkEdge = 1'b0;
            loadValid         = 1'b0;
        end
        check("done_pulse", frameDone, 1);
        check("busy_in_done", busy, 0);
        check("ready_in_done", loadReady, 0);
        check("rx_word", parallelDataOut, exp_par);
        tick();
        check("done_single", frameDone, 0);
        check("ready_after_done", loadReady, 1);
        check("rx_hold", parallelDataOut, exp_par);
        $display("frame tx=%02h rx=%02h lsb=%0d gap<=%0d edge_at_load=%0d -> pdo=%02h bad=%0d",
                 tx, rx, lsb, max_gap, edge_at_load, parallelDataOut, bad);
    endtask

    initial begin
        logic [W-1:0] tx, rx, hold;
        logic         lsb;
        int           first_accept;

        vecs[0] = '{tx: 8'hA5, rx: 8'h3C, lsb: 1'b0, exp_seq: 8'hA5, exp_par: 8'h3C};
        vecs[1] = '{tx: 8'h01, rx: 8'h80, lsb: 1'b1, exp_seq: 8'h80, exp_par: 8'h80};
        vecs[2] = '{tx: 8'hF0, rx: 8'h0F, lsb: 1'b1, exp_seq: 8'h0F, exp_par: 8'h0F};
        vecs[3] = '{tx: 8'h5A, rx: 8'hC3, lsb: 1'b0, exp_seq: 8'h5A, exp_par: 8'hC3};

        // Reset with random inputs toggling
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            peripheralClkEdge = 1'($urandom);
            loadValid         = 1'($urandom);
            parallelDataIn    = W'($urandom);
            lsbFirst          = 1'($urandom);
            serialDataIn      = 1'($urandom);
            tick();
        end
        reset = 1'b0; peripheralClkEdge = 1'b0; loadValid = 1'b0;
        check_reset_values("reset");
        $display("reset applied: loadReady=%0d busy=%0d pdo=%02h", loadReady, busy, parallelDataOut);

        // Directed vector table
        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].tx, vecs[v].rx, vecs[v].lsb, vecs[v].exp_seq, vecs[v].exp_par,
                      (v < 2) ? 0 : 3, 1'b0, 1'b0);
        end

        // Edges while idle must not move the register
        hold = parallelDataOut;
        for (int i = 0; i < 3; i++) begin
            peripheralClkEdge = 1'b1;
            serialDataIn      = ~serialDataIn;
            tick();
        end
        peripheralClkEdge = 1'b0;
        check("idle_edges_pdo", parallelDataOut, hold);
        check("idle_edges_ready", loadReady, 1);
        $display("idle edges: pdo=%02h", parallelDataOut);

        // Load and edge together: the edge is dropped, 8 more are needed
        run_frame(8'h96, 8'h69, 1'b0, 8'h96, 8'h69, 0, 1'b1, 1'b0);

        // Back-to-back frames at full edge rate
        run_frame(8'hC7, 8'h2E, 1'b1, model_seq(8'hC7, 1'b1), 8'h2E, 0, 1'b0, 1'b0);
        first_accept = accept_cyc;
        run_frame(8'h3D, 8'hB1, 1'b0, model_seq(8'h3D, 1'b0), 8'hB1, 0, 1'b0, 1'b0);
        check("frame_period", accept_cyc - first_accept, W + 2);
        $display("back-to-back period=%0d", accept_cyc - first_accept);

        // Random frames with irregular edges and ignored loads / order changes
        for (int f = 0; f < 8; f++) begin
            tx  = W'($urandom);
            rx  = W'($urandom);
            lsb = 1'($urandom);
            run_frame(tx, rx, lsb, model_seq(tx, lsb), rx, 5, 1'($urandom), 1'b1);
        end

        // Mid-frame reset after 3 edges
        loadValid = 1'b1; parallelDataIn = 8'hE7; lsbFirst = 1'b0;
        tick();
        loadValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            peripheralClkEdge = 1'b1;
            serialDataIn      = 1'b1;
            tick();
        end
        peripheralClkEdge = 1'b0;
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("midreset");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midreset_no_done", frameDone, 0);
        end
        $display("mid-frame reset: busy=%0d loadReady=%0d", busy, loadReady);
        rx = W'($urandom);
        run_frame(8'hFF, rx, 1'b0, 8'hFF, rx, 2, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end want end");
        $fatal(1, "timeout");
    end

endmodule
